// File: rtl/lem_dma_pkg.sv
// Shared types and default sizes for the LEM1802 DMA refresh scheduler.
package lem_dma_pkg;

  localparam int unsigned SCR_WORDS_DEF  = 384;
  localparam int unsigned FONT_WORDS_DEF = 256;
  localparam int unsigned PAL_WORDS_DEF  = 16;
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned IDX_W          = 9;

  typedef enum logic [1:0] {
    CMD_MAP_SCREEN  = 2'd0,
    CMD_MAP_FONT    = 2'd1,
    CMD_MAP_PALETTE = 2'd2,
    CMD_SET_BORDER  = 2'd3
  } cfg_cmd_e;

  typedef enum logic [1:0] {
    SEL_VRAM = 2'd0,
    SEL_FONT = 2'd1,
    SEL_PAL  = 2'd2
  } loc_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCREEN,
    ST_FONT,
    ST_PALETTE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lem_dma_addr_gen.sv
// Region address generator: base + idx with 16-bit wrap, idx counter and
// last-word flag. Reloaded at each region entry; load wins over advance.
module lem_dma_addr_gen
  import lem_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IDX_W-1:0]  last_idx_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      idx_q  <= '0;
      last_q <= last_idx_i;
    end else if (adv_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign addr_o = base_q + ADDR_W'(idx_q);
  assign idx_o  = idx_q;
  assign last_o = (idx_q == last_q);

endmodule

// File: rtl/lem_dma_scheduler.sv
// LEM1802 per-frame DMA refresh of VRAM, font and palette local RAMs.
// Optional LEM_DMA_FAIRNESS_EN: one idle request cycle after every grant.
module lem_dma_scheduler
  import lem_dma_pkg::*;
#(
  parameter int unsigned SCR_WORDS  = SCR_WORDS_DEF,
  parameter int unsigned FONT_WORDS = FONT_WORDS_DEF,
  parameter int unsigned PAL_WORDS  = PAL_WORDS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              vsync,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_cmd,
  input  logic [15:0]       cfg_value,
  output logic              cfg_ready,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_gnt,
  input  logic [15:0]       dma_q,
  output logic              loc_wren,
  output logic [1:0]        loc_sel,
  output logic [8:0]        loc_addr,
  output logic [15:0]       loc_data,
  output logic [3:0]        border_colour,
  output logic              scr_enable,
  output logic              font_custom,
  output logic              pal_custom,
  output logic              pass_done
);

  state_e            state_q, state_d;
  logic              vsync_q, pending_q, pending_d, rise, start;
  logic [ADDR_W-1:0] scr_base_q, font_base_q, pal_base_q;
  logic [ADDR_W-1:0] font_sh_q, pal_sh_q;
  logic [3:0]        border_q;
  logic              scr_en_q, font_cus_q, pal_cus_q;
  logic              wr_q, in_region, grant, load, last;
  loc_sel_e          sel_q, cur_sel;
  logic [IDX_W-1:0]  laddr_q, idx, ld_last;
  logic [ADDR_W-1:0] ld_base;

  function automatic state_e next_region(input logic s, input logic f, input logic p);
    if (s) return ST_SCREEN;
    if (f) return ST_FONT;
    if (p) return ST_PALETTE;
    return ST_DONE;
  endfunction

  assign rise      = vsync & ~vsync_q;
  assign in_region = state_q inside {ST_SCREEN, ST_FONT, ST_PALETTE};
  assign grant     = dma_req & dma_gnt;

`ifdef LEM_DMA_FAIRNESS_EN
  logic gap_q;
  always_ff @(posedge CLK) begin
    if (RESET) gap_q <= 1'b0;
    else       gap_q <= grant;
  end
  assign dma_req = in_region & ~gap_q;
`else
  assign dma_req = in_region;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // DONE waits out the pipelined final write so pass_done trails it by a cycle.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start     = 1'b0;
    case (state_q)
      ST_IDLE:    if (rise) start = 1'b1;
      ST_SCREEN:  if (grant && last)
                    state_d = next_region(1'b0, |font_sh_q, |pal_sh_q);
      ST_FONT:    if (grant && last)
                    state_d = next_region(1'b0, 1'b0, |pal_sh_q);
      ST_PALETTE: if (grant && last) state_d = ST_DONE;
      ST_DONE:    if (!wr_q) begin
                    if (pending_q || rise) start = 1'b1;
                    else                   state_d = ST_IDLE;
                  end
      default:    state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d   = next_region(|scr_base_q, |font_base_q, |pal_base_q);
      pending_d = 1'b0;
    end else if (rise && state_q != ST_IDLE) begin
      pending_d = 1'b1;
    end
  end

  // At pass start the shadows are not yet loaded, so regions take the live base.
  always_comb begin
    load    = 1'b0;
    ld_base = '0;
    ld_last = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_SCREEN: begin
          load = 1'b1; ld_base = scr_base_q; ld_last = IDX_W'(SCR_WORDS - 1);
        end
        ST_FONT: begin
          load = 1'b1; ld_base = start ? font_base_q : font_sh_q;
          ld_last = IDX_W'(FONT_WORDS - 1);
        end
        ST_PALETTE: begin
          load = 1'b1; ld_base = start ? pal_base_q : pal_sh_q;
          ld_last = IDX_W'(PAL_WORDS - 1);
        end
        default: load = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_SCREEN: cur_sel = SEL_VRAM;
      ST_FONT:   cur_sel = SEL_FONT;
      default:   cur_sel = SEL_PAL;
    endcase
  end

  lem_dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (load),
    .base_i     (ld_base),
    .last_idx_i (ld_last),
    .adv_i      (grant),
    .addr_o     (dma_addr),
    .idx_o      (idx),
    .last_o     (last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vsync_q     <= 1'b0;
      scr_base_q  <= '0;
      font_base_q <= '0;
      pal_base_q  <= '0;
      font_sh_q   <= '0;
      pal_sh_q    <= '0;
      border_q    <= '0;
      scr_en_q    <= 1'b0;
      font_cus_q  <= 1'b0;
      pal_cus_q   <= 1'b0;
      wr_q        <= 1'b0;
      sel_q       <= SEL_VRAM;
      laddr_q     <= '0;
    end else begin
      vsync_q <= vsync;
      wr_q    <= grant;
      sel_q   <= cur_sel;
      laddr_q <= idx;
      if (cfg_valid) begin
        case (cfg_cmd_e'(cfg_cmd))
          CMD_MAP_SCREEN:  scr_base_q  <= cfg_value[ADDR_W-1:0];
          CMD_MAP_FONT:    font_base_q <= cfg_value[ADDR_W-1:0];
          CMD_MAP_PALETTE: pal_base_q  <= cfg_value[ADDR_W-1:0];
          default:         border_q    <= cfg_value[3:0];
        endcase
      end
      // Screen needs no base shadow: it is only ever entered at pass start.
      if (start) begin
        font_sh_q  <= font_base_q;
        pal_sh_q   <= pal_base_q;
        scr_en_q   <= |scr_base_q;
        font_cus_q <= |font_base_q;
        pal_cus_q  <= |pal_base_q;
      end
    end
  end

  assign cfg_ready     = 1'b1;
  assign loc_wren      = wr_q;
  assign loc_sel       = sel_q;
  assign loc_addr      = laddr_q;
  assign loc_data      = dma_q;
  assign border_colour = border_q;
  assign scr_enable    = scr_en_q;
  assign font_custom   = font_cus_q;
  assign pal_custom    = pal_cus_q;
  assign pass_done     = (state_q == ST_DONE) && !wr_q;

endmodule
